alu_mdu: RTL
============

# alu_mdu

Parametrised, handshaked execute unit for the RISC-V pipeline. It registers the base integer ALU operations with correct signed and unsigned semantics. It adds iterative multiply/divide (RV32M/RV64M) behind a valid/ready interface, so the pipeline can stall on multi-cycle operations. It sits in the EX stage between operand forwarding and the EX/MEM register.

## Interface
- XLEN, 32: operand and result width; 32 or 64.
- TAG_W, 5: width of the sideband tag carried alongside each operation (destination register index).
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of any in-flight or held operation.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation this cycle.
- alu_op  in  6  operation code; see Operation.
- data_in_1  in  XLEN  operand rs1.
- data_in_2  in  XLEN  operand rs2 or immediate.
- in_tag  in  TAG_W  sideband tag, returned unmodified.
- out_valid  out  1  result held on data_out.
- out_ready  in  1  downstream consumes the result this cycle.
- data_out  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- illegal_op  out  1  qualifies out_valid: alu_op was undefined.

## Operation
- Opcodes, fixed:
  - 0/10 ADD
  - 1 SUB
  - 2/11 XOR
  - 3/12 OR
  - 4/13 AND
  - 5/14 SLL
  - 6/15 SRL
  - 7/16 SRA (arithmetic)
  - 8/17 SLT (signed)
  - 9/18 SLTU (unsigned)
  - 19 MUL
  - 20 MULH
  - 21 MULHSU
  - 22 MULHU
  - 23 DIV
  - 24 DIVU
  - 25 REM
  - 26 REMU
  - 27-63 illegal.
- Shift amount is data_in_2[$clog2(XLEN)-1:0]; upper bits are ignored.
- SLT/SLTU results are zero-extended 0 or 1.
- Add, subtract and multiply wrap modulo 2^XLEN.
- MUL returns the low XLEN bits of the product.
- MULH, MULHSU and MULHU return the high XLEN bits of the 2·XLEN product, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide by zero: DIV and DIVU return all-ones; REM and REMU return data_in_1.
- Signed overflow (-2^(XLEN-1) / -1): DIV returns data_in_1; REM returns 0.
- Signed DIV truncates toward zero. REM takes the sign of the dividend.
- Illegal opcode: data_out=0 and illegal_op=1, with the single-cycle latency.
- State machine:
  - IDLE: in_ready=1. On accept, a single-cycle op computes and latches into DONE. Mul/div with a nonzero divisor goes to BUSY with the counter at XLEN. Division by zero and signed overflow skip BUSY and go straight to DONE.
  - BUSY: in_ready=0. One shift-add (mul) or one restoring-subtract (div) step per cycle. The counter decrements; at 1, apply sign correction and go to DONE.
  - DONE: out_valid=1. Outputs hold stable until out_ready. In the same cycle as out_ready, in_ready=1, so a new accept in that cycle goes directly to its next state without a bubble. With out_ready and no new accept, go to IDLE.
- flush=1: next state is IDLE and out_valid drops. Any in_valid in that cycle is ignored (in_ready is forced to 0). flush takes priority over out_ready and over the BUSY step.
- reset: overrides flush and returns to IDLE from any state, including mid-iteration.

## Timing
- Reset values: out_valid=0, data_out=0, out_tag=0, illegal_op=0, state=IDLE, counter=0. in_ready is 1 from the first cycle after reset.
- Accept occurs on a rising edge where in_valid & in_ready & !flush.
- Single-cycle ops: out_valid is asserted the cycle after accept (latency 1). Throughput is 1 per cycle while out_ready=1.
- Mul/div: out_valid is asserted XLEN+1 cycles after accept (33 for XLEN=32).
- Div-by-zero and signed-overflow cases: latency 1.
- data_out, out_tag and illegal_op change only on the transition into DONE, or on reset.
- Inputs are sampled only at accept. They may change freely while BUSY.

## Test plan
- Reset, then ops 7 and 8 with data_in_1=0x8000_0000 and data_in_2=4 / 0x0000_0001. Required: SRA → 0xF800_0000; SLT → 1. SLTU with the same operands → 0.
- Back-to-back single-cycle stream of ADD, SUB, SLL with out_ready=1:
  - ADD 0xFFFF_FFFF+1 → 0.
  - SUB 0-1 → 0xFFFF_FFFF.
  - SLL 1<<33 → 2, since the shift amount is masked to 1.
  - Required: one result per cycle, tags in order.
- MULH(0xFFFF_FFFF, 0xFFFF_FFFF) → 0 and MULHU of the same operands → 0xFFFF_FFFE. Required: out_valid exactly 33 cycles after accept, and in_ready=0 throughout.
- Division corner cases:
  - DIV 7/0 → 0xFFFF_FFFF.
  - REMU 7/0 → 7.
  - DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000, and REM of the same → 0.
  - DIV -7/2 → -3 (0xFFFF_FFFD); REM -7/2 → -1 (0xFFFF_FFFF).
- Backpressure: hold out_ready=0 for 5 cycles after a result. Required: data_out and out_tag stay stable and in_ready=0; raising out_ready with in_valid=1 produces the next result on the following cycle.
- Flush on BUSY cycle 10 of a DIVU, with in_valid=1 in that cycle. Required: no out_valid, IDLE next cycle, and that in-cycle operation dropped. Repeat with reset instead of flush: same outcome, all outputs 0.

Source files
------------

// File: rtl/alu_mdu_if.sv
// Handshake bundle for alu_mdu: operation request channel and result channel.
interface alu_mdu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       alu_op;
    logic [XLEN-1:0]  data_in_1;
    logic [XLEN-1:0]  data_in_2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  data_out;
    logic [TAG_W-1:0] out_tag;
    logic             illegal_op;

    modport master (
        output in_valid, alu_op, data_in_1, data_in_2, in_tag, out_ready,
        input  in_ready, out_valid, data_out, out_tag, illegal_op
    );

    modport slave (
        input  in_valid, alu_op, data_in_1, data_in_2, in_tag, out_ready,
        output in_ready, out_valid, data_out, out_tag, illegal_op
    );
endinterface

// File: rtl/alu_mdu.sv
// EX-stage execute unit: single-cycle integer ALU plus iterative RV32M/RV64M
// multiply/divide (shift-add and restoring divide) behind a valid/ready handshake.
module alu_mdu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic        clock,
    input logic        reset,
    input logic        flush,
    alu_mdu_if.slave   bus
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  hi, lo, opb;
    logic             md_div, md_sel_hi, md_neg;
    logic [TAG_W-1:0] tag_hold;
    logic [XLEN-1:0]  data_q;
    logic [TAG_W-1:0] tag_q;
    logic             ill_q;

    logic [5:0]       op;
    logic [XLEN-1:0]  a, b, a_mag, b_mag;
    logic [SH_W-1:0]  shamt;
    logic             is_mul, is_div, is_illegal;
    logic             signed_a, signed_b, a_neg, b_neg;
    logic             div_zero, div_ovf, go_busy;
    logic             in_ready, accept;
    logic             neg_nx, sel_hi_nx;
    logic [XLEN-1:0]  fast_res;

    assign op    = bus.alu_op;
    assign a     = bus.data_in_1;
    assign b     = bus.data_in_2;
    assign shamt = b[SH_W-1:0];
    assign a_neg = a[XLEN-1];
    assign b_neg = b[XLEN-1];

    always_comb begin
        is_mul     = (op >= 6'd19) && (op <= 6'd22);
        is_div     = (op >= 6'd23) && (op <= 6'd26);
        is_illegal = (op >= 6'd27);
        signed_a   = (op == 6'd20) || (op == 6'd21) || (op == 6'd23) || (op == 6'd25);
        signed_b   = (op == 6'd20) || (op == 6'd23) || (op == 6'd25);
        a_mag      = (signed_a && a_neg) ? -a : a;
        b_mag      = (signed_b && b_neg) ? -b : b;
        div_zero   = is_div && (b == '0);
        div_ovf    = ((op == 6'd23) || (op == 6'd25)) &&
                     (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        go_busy    = (is_mul || is_div) && !div_zero && !div_ovf;
        // REM follows the dividend's sign; quotient and products follow the XOR of signs
        neg_nx     = (op == 6'd25) ? a_neg : ((signed_a & a_neg) ^ (signed_b & b_neg));
        sel_hi_nx  = (op == 6'd20) || (op == 6'd21) || (op == 6'd22) ||
                     (op == 6'd25) || (op == 6'd26);
    end

    assign in_ready = !flush && ((state == IDLE) || ((state == DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        fast_res = '0;
        case (op)
            6'd0, 6'd10:  fast_res = a + b;
            6'd1:         fast_res = a - b;
            6'd2, 6'd11:  fast_res = a ^ b;
            6'd3, 6'd12:  fast_res = a | b;
            6'd4, 6'd13:  fast_res = a & b;
            6'd5, 6'd14:  fast_res = a << shamt;
            6'd6, 6'd15:  fast_res = a >> shamt;
            6'd7, 6'd16:  fast_res = $signed(a) >>> shamt;
            6'd8, 6'd17:  fast_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            6'd9, 6'd18:  fast_res = {{(XLEN-1){1'b0}}, (a < b)};
            6'd23, 6'd24: fast_res = div_zero ? '1 : a;
            6'd25, 6'd26: fast_res = div_zero ? a : '0;
            default:      fast_res = '0;
        endcase
    end

    // One iteration step: hi/lo form the product (mul) or remainder/quotient (div)
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo, div_sel, div_res, mul_res, mdu_res;
    logic [2*XLEN-1:0] full_neg;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (md_div) begin
            step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end
        full_neg = -{step_hi, step_lo};
        mul_res  = md_sel_hi ? (md_neg ? full_neg[2*XLEN-1:XLEN] : step_hi)
                             : (md_neg ? full_neg[XLEN-1:0]      : step_lo);
        div_sel  = md_sel_hi ? step_hi : step_lo;
        div_res  = md_neg ? -div_sel : div_sel;
        mdu_res  = md_div ? div_res : mul_res;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = go_busy ? BUSY : DONE;
            BUSY: if (cnt == CNT_W'(1)) state_nx = DONE;
            DONE: begin
                if (accept)             state_nx = go_busy ? BUSY : DONE;
                else if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            opb       <= '0;
            md_div    <= 1'b0;
            md_sel_hi <= 1'b0;
            md_neg    <= 1'b0;
            tag_hold  <= '0;
            data_q    <= '0;
            tag_q     <= '0;
            ill_q     <= 1'b0;
        end else if (accept) begin
            if (go_busy) begin
                hi        <= '0;
                lo        <= is_div ? a_mag : b_mag;
                opb       <= is_div ? b_mag : a_mag;
                md_div    <= is_div;
                md_sel_hi <= sel_hi_nx;
                md_neg    <= neg_nx;
                cnt       <= CNT_W'(XLEN);
                tag_hold  <= bus.in_tag;
            end else begin
                data_q <= fast_res;
                tag_q  <= bus.in_tag;
                ill_q  <= is_illegal;
            end
        end else if (flush) begin
            cnt <= '0;
        end else if (state == BUSY) begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                data_q <= mdu_res;
                tag_q  <= tag_hold;
                ill_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state == DONE);
    assign bus.data_out   = data_q;
    assign bus.out_tag    = tag_q;
    assign bus.illegal_op = ill_q;
endmodule
